// File: rtl/sram_mem_responder.sv
// rtl/sram_mem_responder.sv - main-memory responder for the cache<->SRAM handshake
//
// Accepts single-word read/write requests from the cache controller, holds
// ready_sram low for a fixed per-operation latency, then completes the access
// against an internal word array.
//
// Ports:
//   clk         system clock (shared with the cache controller)
//   reset       synchronous, active-low reset
//   addr_sram   request address; only the low MEM_AW bits select a word
//   rd_sram     read request
//   wr_sram     write request
//   wdata_sram  write data, captured at accept
//   rdata_sram  registered read data
//   rdata_oe    high while rdata_sram holds valid read data
//   ready_sram  high = idle/complete, low = busy
//   err_sram    one-cycle pulse when rd and wr are both high at accept
module sram_mem_responder #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32,
  parameter int MEM_AW = 10,
  parameter int RD_LAT = 4,
  parameter int WR_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_sram,
  input  logic              rd_sram,
  input  logic              wr_sram,
  input  logic [DATA_W-1:0] wdata_sram,
  output logic [DATA_W-1:0] rdata_sram,
  output logic              rdata_oe,
  output logic              ready_sram,
  output logic              err_sram
);

  // The counter only ever holds LAT-1, so it needs enough bits for that value.
  localparam int LAT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
  localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(WR_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [MEM_AW-1:0] idx, idx_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic              op_wr, op_wr_n;
  logic              ready_n, oe_n, err_n;
  logic              mem_we, mem_re;

  logic [DATA_W-1:0] mem [2**MEM_AW];

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    wdata_n = wdata_q;
    op_wr_n = op_wr;
    ready_n = ready_sram;
    oe_n    = rdata_oe;
    err_n   = 1'b0;
    mem_we  = 1'b0;
    mem_re  = 1'b0;

    case (state)
      IDLE: begin
        ready_n = 1'b1;
        if (rd_sram || wr_sram) begin
          // Truncating cast: upper address bits alias onto the array.
          idx_n   = MEM_AW'(addr_sram);
          wdata_n = wdata_sram;
          // A simultaneous rd+wr performs the read and drops the write.
          op_wr_n = wr_sram && !rd_sram;
          cnt_n   = rd_sram ? RD_CNT : WR_CNT;
          err_n   = rd_sram && wr_sram;
          oe_n    = 1'b0;
          ready_n = 1'b0;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          ready_n = 1'b1;
          state_n = DONE;
          if (op_wr) begin
            mem_we = 1'b1;
          end else begin
            mem_re = 1'b1;
            oe_n   = 1'b1;
          end
        end
      end
      DONE: begin
        // Request lines lag ready by a cycle; wait for them to drop before
        // re-arming so a held request is not accepted twice.
        if (!rd_sram && !wr_sram) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      ready_sram <= 1'b1;
      rdata_sram <= '0;
      rdata_oe   <= 1'b0;
      err_sram   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      ready_sram <= ready_n;
      rdata_oe   <= oe_n;
      err_sram   <= err_n;
      if (mem_re) begin
        rdata_sram <= mem[idx];
      end
    end
  end

  // Request capture registers need no reset: they are always loaded at accept.
  always_ff @(posedge clk) begin
    idx     <= idx_n;
    wdata_q <= wdata_n;
    op_wr   <= op_wr_n;
  end

  // Array is not reset; gating with reset discards a write aborted at commit.
  always_ff @(posedge clk) begin
    if (reset && mem_we) begin
      mem[idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_sram_mem_responder.sv
// tb/tb_sram_mem_responder.sv - self-checking bench for sram_mem_responder
module tb_sram_mem_responder;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;
  localparam int MEM_AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [ADDR_W-1:0] addr  [2];
  logic              rd    [2];
  logic              wr    [2];
  logic [DATA_W-1:0] wdata [2];
  logic [DATA_W-1:0] rdata [2];
  logic              oe    [2];
  logic              ready [2];
  logic              err   [2];

  int rd_lat [2] = '{4, 1};
  int wr_lat [2] = '{4, 7};

  logic [DATA_W-1:0] model [2][2**MEM_AW];

  int n_checks = 0;
  int n_errors = 0;

  sram_mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW), .RD_LAT(4), .WR_LAT(4)
  ) u_dut (
    .clk(clk), .reset(reset), .addr_sram(addr[0]), .rd_sram(rd[0]), .wr_sram(wr[0]),
    .wdata_sram(wdata[0]), .rdata_sram(rdata[0]), .rdata_oe(oe[0]),
    .ready_sram(ready[0]), .err_sram(err[0])
  );

  sram_mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW), .RD_LAT(1), .WR_LAT(7)
  ) u_dut_skew (
    .clk(clk), .reset(reset), .addr_sram(addr[1]), .rd_sram(rd[1]), .wr_sram(wr[1]),
    .wdata_sram(wdata[1]), .rdata_sram(rdata[1]), .rdata_oe(oe[1]),
    .ready_sram(ready[1]), .err_sram(err[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request held for a single accept edge; measures ready-low width and
  // checks the completion against the model.
  task automatic access(input int s, input bit r, input bit w,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input bit no_wait);
    int low;
    int exp_lat;
    int i;
    i       = int'(a) % (2**MEM_AW);
    exp_lat = r ? rd_lat[s] : wr_lat[s];
    if (!no_wait) @(negedge clk);
    rd[s] = r; wr[s] = w; addr[s] = a; wdata[s] = d;
    @(negedge clk);
    rd[s] = 1'b0; wr[s] = 1'b0;
    addr[s] = ADDR_W'($urandom); wdata[s] = $urandom;
    chk("err_at_accept", err[s], 32'(r && w));
    chk("oe_clear_at_accept", oe[s], 0);
    low = 0;
    while (!ready[s] && low < 64) begin
      low++;
      @(negedge clk);
      if (low == 1) chk("err_one_cycle", err[s], 0);
    end
    chk("ready_low_width", low, exp_lat);
    if (r) begin
      chk("rdata", rdata[s], model[s][i]);
      chk("oe_set", oe[s], 1);
    end else begin
      model[s][i] = d;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int low;
    logic [ADDR_W-1:0] a;
    for (int s = 0; s < 2; s++) begin
      rd[s] = 1'b0; wr[s] = 1'b0; addr[s] = '0; wdata[s] = '0;
    end

    // Reset and release.
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_ready", ready[s], 1);
      chk("rst_oe", oe[s], 0);
      chk("rst_err", err[s], 0);
    end

    // Write then read back.
    access(0, 0, 1, 17'h00005, 32'hDEADBEEF, 0);
    access(0, 1, 0, 17'h00005, 32'h0, 0);
    chk("wr_rd_value", rdata[0], 32'hDEADBEEF);

    // Cache-style handshake: rd held one edge past ready rising.
    @(negedge clk);
    rd[0] = 1'b1; addr[0] = 17'h00005;
    @(negedge clk);
    low = 0;
    while (!ready[0] && low < 64) begin
      low++;
      @(negedge clk);
    end
    chk("hs_width", low, 4);
    chk("hs_rdata", rdata[0], 32'hDEADBEEF);
    @(negedge clk);
    chk("hs_no_reaccept", ready[0], 1);
    rd[0] = 1'b0;
    @(negedge clk);
    chk("hs_idle_ready", ready[0], 1);
    chk("hs_oe_held", oe[0], 1);
    // Responder must be in IDLE now: a request presented immediately is accepted.
    access(0, 1, 0, 17'h00005, 32'h0, 1);

    // Address aliasing and rd+wr collision.
    access(0, 0, 1, 17'h00403, 32'h12345678, 0);
    access(0, 1, 0, 17'h00003, 32'h0, 0);
    chk("alias_value", rdata[0], 32'h12345678);
    access(0, 1, 1, 17'h00003, 32'h0, 0);
    chk("collide_read", rdata[0], 32'h12345678);
    access(0, 1, 0, 17'h00003, 32'h0, 0);
    chk("collide_array_kept", rdata[0], 32'h12345678);

    // Reset aborts an in-flight write.
    access(0, 0, 1, 17'h00010, 32'h11111111, 0);
    @(negedge clk);
    wr[0] = 1'b1; addr[0] = 17'h00010; wdata[0] = 32'hA5A5A5A5;
    @(negedge clk);
    wr[0] = 1'b0;
    chk("abort_busy1", ready[0], 0);
    @(negedge clk);
    chk("abort_busy2", ready[0], 0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", ready[0], 1);
    chk("abort_oe", oe[0], 0);
    chk("abort_rdata", rdata[0], 0);
    reset = 1'b1;
    access(0, 1, 0, 17'h00010, 32'h0, 0);
    chk("abort_kept_old", rdata[0], 32'h11111111);

    // Skewed-latency build, back-to-back with one idle cycle between.
    access(1, 0, 1, 17'h00055, 32'hCAFEF00D, 0);
    access(1, 1, 0, 17'h00055, 32'h0, 0);
    chk("skew_rd1", rdata[1], 32'hCAFEF00D);
    access(1, 0, 1, 17'h00056, 32'h0BADF00D, 0);
    access(1, 0, 1, 17'h00456, 32'h600DF00D, 0);
    access(1, 1, 0, 17'h00056, 32'h0, 0);
    chk("skew_rd2", rdata[1], 32'h600DF00D);

    // Randomized traffic on both builds over a small aliased index window.
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 8; k++) begin
        a = {7'($urandom_range(0, 127)), 10'(10'h020 + k)};
        access(s, 0, 1, a, $urandom, 0);
      end
      for (int n = 0; n < 40; n++) begin
        int op;
        op = $urandom_range(0, 2);
        a  = {7'($urandom_range(0, 127)), 10'(10'h020 + $urandom_range(0, 7))};
        access(s, op != 1, op != 0, a, $urandom, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
